// File: rtl/imdct_demux_2_stream_if.sv
// Valid/ready bundle for the IMDCT 1:2 demultiplexer: one input stream, two output channels.
interface imdct_demux_2_stream_if #(
  parameter int unsigned N = 18
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         a_valid;
  logic         a_ready;
  logic [N-1:0] a_data;
  logic         b_valid;
  logic         b_ready;
  logic [N-1:0] b_data;

  // master: upstream producer plus both channel consumers
  modport master (
    output in_valid, in_data, a_ready, b_ready,
    input  in_ready, a_valid, a_data, b_valid, b_data
  );

  modport slave (
    input  in_valid, in_data, a_ready, b_ready,
    output in_ready, a_valid, a_data, b_valid, b_data
  );
endinterface

// File: rtl/imdct_demux_2_stream.sv
// Steers consecutive BLOCK_LEN-sample blocks alternately to channel A and channel B,
// each channel backed by its own one-entry output register.
module imdct_demux_2_stream #(
  parameter int unsigned N         = 18,
  parameter int unsigned BLOCK_LEN = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  imdct_demux_2_stream_if.slave  bus,
  output logic                   dest,
  output logic                   block_done
);
  localparam int unsigned CW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLOCK_LEN - 1);

  logic [CW-1:0] cnt, cnt_n;
  logic          dest_n, block_done_n;
  logic          a_valid_q, a_valid_n, b_valid_q, b_valid_n;
  logic [N-1:0]  a_data_q, a_data_n, b_data_q, b_data_n;
  logic          in_ready_c, accept_c;

  // Readiness looks only at the channel currently being filled.
  assign in_ready_c = dest ? (!b_valid_q || bus.b_ready) : (!a_valid_q || bus.a_ready);
  assign accept_c   = bus.in_valid && in_ready_c;

  always_comb begin
    cnt_n        = cnt;
    dest_n       = dest;
    block_done_n = 1'b0;
    a_valid_n    = a_valid_q;
    a_data_n     = a_data_q;
    b_valid_n    = b_valid_q;
    b_data_n     = b_data_q;

    if (accept_c) begin
      if (cnt == LAST) begin
        cnt_n        = '0;
        dest_n       = !dest;
        block_done_n = 1'b1;
      end else begin
        cnt_n = cnt + CW'(1);
      end
    end

    // A reload in the same cycle as a drain keeps valid high with the new sample.
    if (accept_c && !dest) begin
      a_valid_n = 1'b1;
      a_data_n  = bus.in_data;
    end else if (a_valid_q && bus.a_ready) begin
      a_valid_n = 1'b0;
    end

    if (accept_c && dest) begin
      b_valid_n = 1'b1;
      b_data_n  = bus.in_data;
    end else if (b_valid_q && bus.b_ready) begin
      b_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      dest       <= 1'b0;
      block_done <= 1'b0;
      a_valid_q  <= 1'b0;
      a_data_q   <= '0;
      b_valid_q  <= 1'b0;
      b_data_q   <= '0;
    end else begin
      cnt        <= cnt_n;
      dest       <= dest_n;
      block_done <= block_done_n;
      a_valid_q  <= a_valid_n;
      a_data_q   <= a_data_n;
      b_valid_q  <= b_valid_n;
      b_data_q   <= b_data_n;
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.a_valid  = a_valid_q;
  assign bus.a_data   = a_data_q;
  assign bus.b_valid  = b_valid_q;
  assign bus.b_data   = b_data_q;
endmodule

// File: tb/tb_imdct_demux_2_stream.sv
// Scoreboard bench: unit 0 uses BLOCK_LEN = 18, unit 1 uses BLOCK_LEN = 1.
module tb_imdct_demux_2_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imdct_demux_2_stream_if #(.N(18)) if0 ();
  imdct_demux_2_stream_if #(.N(18)) if1 ();

  logic [1:0]  iv = 2'b11;
  logic [1:0]  ar = 2'b11;
  logic [1:0]  br = 2'b11;
  logic [17:0] id [2];
  logic [1:0]  dst, bdn;
  logic [1:0]  ir, av, bv;
  logic [17:0] ad [2];
  logic [17:0] bdat [2];

  assign if0.in_valid = iv[0];
  assign if0.in_data  = id[0];
  assign if0.a_ready  = ar[0];
  assign if0.b_ready  = br[0];
  assign if1.in_valid = iv[1];
  assign if1.in_data  = id[1];
  assign if1.a_ready  = ar[1];
  assign if1.b_ready  = br[1];
  assign ir    = {if1.in_ready, if0.in_ready};
  assign av    = {if1.a_valid, if0.a_valid};
  assign bv    = {if1.b_valid, if0.b_valid};
  assign ad[0] = if0.a_data;
  assign ad[1] = if1.a_data;
  assign bdat[0] = if0.b_data;
  assign bdat[1] = if1.b_data;

  imdct_demux_2_stream #(.N(18), .BLOCK_LEN(18)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0), .dest(dst[0]), .block_done(bdn[0]));
  imdct_demux_2_stream #(.N(18), .BLOCK_LEN(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1), .dest(dst[1]), .block_done(bdn[1]));

  int nchk = 0;
  int nfail = 0;
  int blen [2] = '{18, 1};
  int mcnt [2] = '{0, 0};
  bit mdest [2] = '{1'b0, 1'b0};
  int bdc [2] = '{0, 0};
  int stalls [2] = '{0, 0};
  logic [17:0] qa0[$], qb0[$], qa1[$], qb1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic push(input int u, input bit ch, input logic [17:0] v);
    case ({u[0], ch})
      2'b00: qa0.push_back(v);
      2'b01: qb0.push_back(v);
      2'b10: qa1.push_back(v);
      default: qb1.push_back(v);
    endcase
  endtask

  task automatic drain(input int u, input bit ch, input logic [17:0] v);
    logic [17:0] e;
    int sz;
    case ({u[0], ch})
      2'b00: sz = qa0.size();
      2'b01: sz = qb0.size();
      2'b10: sz = qa1.size();
      default: sz = qb1.size();
    endcase
    if (sz == 0) begin
      chk($sformatf("u%0d ch%0d unexpected drain", u, ch), 32'(v), 32'hFFFF_FFFF);
    end else begin
      case ({u[0], ch})
        2'b00: e = qa0.pop_front();
        2'b01: e = qb0.pop_front();
        2'b10: e = qa1.pop_front();
        default: e = qb1.pop_front();
      endcase
      chk($sformatf("u%0d ch%0d drain data", u, ch), 32'(v), 32'(e));
    end
  endtask

  // Monitor: every completed output handshake must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      for (int u = 0; u < 2; u++) begin
        if (av[u] && ar[u]) drain(u, 1'b0, ad[u]);
        if (bv[u] && br[u]) drain(u, 1'b1, bdat[u]);
        if (bdn[u]) bdc[u]++;
      end
    end
  end

  // Called at a drive point (1 time unit after a rising edge); returns at the drive point after the accept.
  task automatic send(input int u, input logic [17:0] v);
    bit acc = 1'b0;
    bit ch = 1'b0;
    bit last = 1'b0;
    int budget = 0;
    iv[u] = 1'b1;
    id[u] = v;
    while (!acc && budget < 500) begin
      @(negedge clk);
      if (ir[u]) begin
        acc  = 1'b1;
        ch   = mdest[u];
        last = (mcnt[u] == blen[u] - 1);
        push(u, ch, v);
        if (last) begin
          mcnt[u]  = 0;
          mdest[u] = !mdest[u];
        end else begin
          mcnt[u]++;
        end
      end else begin
        stalls[u]++;
      end
      @(posedge clk);
      #1;
      budget++;
    end
    iv[u] = 1'b0;
    if (!acc) begin
      chk($sformatf("u%0d accept timeout", u), 32'(0), 32'(1));
    end else begin
      chk($sformatf("u%0d latency valid", u), 32'(ch ? bv[u] : av[u]), 32'(1));
      chk($sformatf("u%0d latency data", u), 32'(ch ? bdat[u] : ad[u]), 32'(v));
      chk($sformatf("u%0d block_done", u), 32'(bdn[u]), 32'(last));
      chk($sformatf("u%0d dest", u), 32'(dst[u]), 32'(mdest[u]));
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    qa0.delete(); qb0.delete(); qa1.delete(); qb1.delete();
    mcnt  = '{0, 0};
    mdest = '{1'b0, 1'b0};
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic queues_empty(input string name);
    chk({name, " qa0 empty"}, 32'(qa0.size()), 32'(0));
    chk({name, " qb0 empty"}, 32'(qb0.size()), 32'(0));
    chk({name, " qa1 empty"}, 32'(qa1.size()), 32'(0));
    chk({name, " qb1 empty"}, 32'(qb1.size()), 32'(0));
  endtask

  initial begin
    int b0;
    id[0] = 18'h3FFFF;
    id[1] = 18'h3FFFF;
    // Reset with in_valid held high: nothing may be captured.
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("rst a_valid", 32'(av), 32'(0));
    chk("rst b_valid", 32'(bv), 32'(0));
    chk("rst dest", 32'(dst), 32'(0));
    chk("rst block_done", 32'(bdn), 32'(0));
    chk("rst in_ready", 32'(ir), 32'(2'b11));
    rst = 1'b0;
    iv  = 2'b00;
    idle(1);
    chk("post-rst no capture a", 32'(av), 32'(0));
    chk("post-rst no capture b", 32'(bv), 32'(0));

    // Full-rate alternation on unit 0.
    b0 = bdc[0];
    stalls[0] = 0;
    for (int i = 0; i < 72; i++) send(0, 18'(i));
    idle(2);
    chk("fullrate block_done count", 32'(bdc[0] - b0), 32'(4));
    chk("fullrate in_ready stalls", 32'(stalls[0]), 32'(0));
    queues_empty("fullrate");

    // Target stall while the other channel still drains.
    reset_pulse();
    ar[0] = 1'b1;
    br[0] = 1'b0;
    for (int i = 0; i < 18; i++) send(0, 18'(i));
    ar[0] = 1'b0;
    send(0, 18'd18);
    fork
      send(0, 18'd19);
      begin
        idle(3);
        chk("stall in_ready low", 32'(ir[0]), 32'(0));
        chk("stall b holds 18", 32'(bdat[0]), 32'(18));
        chk("stall a holds 17", 32'(ad[0]), 32'(17));
        chk("stall a valid", 32'(av[0]), 32'(1));
        ar[0] = 1'b1;
        idle(1);
        chk("a drained", 32'(av[0]), 32'(0));
        chk("in_ready still low", 32'(ir[0]), 32'(0));
        br[0] = 1'b1;
      end
    join
    for (int i = 20; i < 36; i++) send(0, 18'(i));
    idle(2);
    queues_empty("stall");

    // Simultaneous drain and reload on channel A.
    reset_pulse();
    send(0, 18'h00012);
    send(0, 18'h00013);
    idle(2);
    queues_empty("drain-reload");

    // BLOCK_LEN = 1 on unit 1.
    b0 = bdc[1];
    for (int i = 5; i < 9; i++) send(1, 18'(i));
    idle(2);
    chk("blen1 block_done count", 32'(bdc[1] - b0), 32'(4));
    queues_empty("blen1");

    // Reset mid-block while filling B.
    reset_pulse();
    for (int i = 0; i < 25; i++) send(0, 18'(i));
    chk("mid-block dest before rst", 32'(dst[0]), 32'(1));
    reset_pulse();
    chk("mid-block dest after rst", 32'(dst[0]), 32'(0));
    chk("mid-block b_valid after rst", 32'(bv[0]), 32'(0));
    b0 = bdc[0];
    for (int i = 100; i < 118; i++) send(0, 18'(i));
    idle(2);
    chk("mid-block block_done count", 32'(bdc[0] - b0), 32'(1));
    chk("mid-block dest toggled", 32'(dst[0]), 32'(1));
    queues_empty("mid-block");

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/imdct_demux_2_stream.md
# imdct_demux_2_stream

Streaming 1-to-2 demultiplexer for the IMDCT stage: takes one valid/ready stream of N-bit samples and steers consecutive blocks of BLOCK_LEN samples alternately to output channel A and output channel B. Each output has its own one-entry output register. A stalled channel therefore never blocks draining of the other. It is the splitting counterpart of the IMDCT 2:1 multiplexers and feeds the two per-subband processing lanes (18 samples per subband block).

## Interface
- N, 18, sample width in bits
- BLOCK_LEN, 18, samples per block before the destination toggles (legal range ≥ 1)
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream sample valid
- in_ready  output  1  block can accept a sample this cycle
- in_data  input  N  upstream sample
- a_valid  output  1  channel A register holds a sample
- a_ready  input  1  channel A consumer accepts
- a_data  output  N  channel A sample
- b_valid  output  1  channel B register holds a sample
- b_ready  input  1  channel B consumer accepts
- b_data  output  N  channel B sample
- dest  output  1  current target channel (0 = A, 1 = B)
- block_done  output  1  one-cycle pulse after the last sample of a block is accepted

## Operation
- Internal state:
  - dest register
  - sample counter cnt, width $clog2(BLOCK_LEN) (min 1), range 0..BLOCK_LEN-1
  - per-channel valid flag and N-bit data register
- in_ready is combinational:
  - dest = 0: in_ready = !a_valid || a_ready
  - dest = 1: in_ready = !b_valid || b_ready
  - It depends only on the target channel. The non-target channel's state is ignored.
- Accept occurs when in_valid && in_ready at a rising edge. On accept:
  - The target channel data register loads in_data and its valid flag is set.
  - If cnt == BLOCK_LEN-1: cnt ← 0, dest toggles, block_done ← 1.
  - Otherwise: cnt ← cnt+1, block_done ← 0.
- With no accept, block_done ← 0.
- Channel drain: when x_valid && x_ready and no reload of that channel in the same cycle, x_valid ← 0.
  - The data register holds its value; it is a don't-care once invalid.
- Simultaneous drain and reload of the target channel: the new sample wins, valid stays 1. No bubble, no loss.
- The non-target channel continues draining independently of input activity.
- BLOCK_LEN = 1: dest toggles on every accepted sample.
- Samples are never reordered, duplicated, or dropped except by reset.
- Sample order within each channel equals input order.

## Timing
- Reset (rst high at a rising edge) forces all of the following to 0 on the next cycle: a_valid, b_valid, a_data, b_data, dest, cnt, block_done.
  - in_ready is then 1.
- Reset mid-block or mid-stall discards buffered samples and restarts the block at channel A, cnt = 0.
- Latency: a sample accepted at edge k is visible on x_data with x_valid = 1 in the cycle after edge k. Latency is 1 cycle.
- Throughput: 1 sample/cycle while the target consumer holds ready high, including across block boundaries.
  - The last sample of block A and the first sample of block B are accepted on consecutive edges.
- block_done is high exactly in the cycle after the accepting edge of sample BLOCK_LEN-1; dest shows the new channel in that same cycle.
- Upstream must hold in_data stable while in_valid && !in_ready.
- x_valid/x_data stay stable until x_ready is sampled high.

## Test plan
- **Reset values**
  - Stimulus: assert rst for 2 cycles with in_valid = 1 and in_data = 0x3FFFF.
  - Required: a_valid = b_valid = 0, dest = 0, block_done = 0, in_ready = 1. No sample is captured.
- **Full-rate alternation**
  - Stimulus: N = 18, BLOCK_LEN = 18, a_ready = b_ready = 1; stream 0..71 back-to-back.
  - Required: A receives 0–17 and 36–53, B receives 18–35 and 54–71, each 1 cycle after accept.
  - Required: block_done pulses 4 times; in_ready never drops.
- **Target stall with other-channel drain**
  - Stimulus: feed the first 18 samples with b_ready = 0, then a_ready = 0 from sample 18 on.
  - Required: B holds sample 18; in_ready = 0 while A still drains its last sample 17 once a_ready = 1.
  - Required: after b_ready rises, samples 19+ flow with no loss.
- **Simultaneous drain/reload**
  - Stimulus: a_valid = 1, a_ready = 1, and a new accept in the same cycle.
  - Required: a_valid stays 1 and a_data updates to the new value (e.g. 0x00012 → 0x00013).
- **BLOCK_LEN = 1**
  - Stimulus: stream 5, 6, 7, 8.
  - Required: A gets 5 and 7, B gets 6 and 8; block_done is high on every cycle following an accept.
- **Reset mid-block**
  - Stimulus: after 7 accepts into B (cnt = 7, dest = 1), pulse rst.
  - Required: dest = 0, cnt restarts; the next 18 samples all go to A, and block_done fires after the 18th.
